put_glyph_line: RTL

//  Writer side of the glyph font store: accepts a code point, then HEIGHT glyph pixel

---
 rtl/put_glyph_line_pkg.sv | 27 ++
 rtl/put_glyph_line_if.sv | 11 +
 rtl/put_glyph_line.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/put_glyph_line_pkg.sv
// Shared types and helpers for the glyph font store (writer and line reader).
package put_glyph_line_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2
  } glyph_wr_state_t;

  localparam int unsigned REV_MAX = 64;

  // Mirror the low w bits of v; bits at and above w come back as zero.
  function automatic logic [REV_MAX-1:0] bit_rev(input logic [REV_MAX-1:0] v,
                                                 input int unsigned w);
    logic [REV_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < REV_MAX; i++) begin
      if (i < w) begin
        r[i] = v[6'(w - 32'd1 - i)];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/put_glyph_line_if.sv
// Pixel line stream from the font upload source into the glyph line writer.
interface put_glyph_line_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] line_data;
  logic             line_valid;
  logic             line_ready;

  modport master (output line_data, output line_valid, input line_ready);
  modport slave  (input line_data, input line_valid, output line_ready);
endinterface

// File: rtl/put_glyph_line.sv
// Glyph line writer: code point + HEIGHT pixel lines -> font RAM writes at (ucp-OFFSET)*HEIGHT+line.
// Optional PUT_GLYPH_LINE_CLEAR_EN adds clear_i, which zero-fills the whole font RAM.
module put_glyph_line
  import put_glyph_line_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 16,
  parameter int unsigned COUNT  = 256,
  parameter int unsigned OFFSET = 0,
  parameter bit          LSB    = 1'b0,
  localparam int unsigned DEPTH = HEIGHT * COUNT,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [7:0]       ucp_i,
`ifdef PUT_GLYPH_LINE_CLEAR_EN
  input  logic             clear_i,
`endif
  put_glyph_line_if.slave  line,
  output logic             ram_we_o,
  output logic [AW-1:0]    ram_addr_o,
  output logic [WIDTH-1:0] ram_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned CW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [8:0]  UCP_LO = 9'(OFFSET);
  localparam logic [8:0]  SLOTS  = 9'(COUNT);
  localparam logic [AW-1:0] H_A  = AW'(HEIGHT);
  localparam logic [CW-1:0] LAST_LINE = CW'(HEIGHT - 1);

  glyph_wr_state_t state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ram_we_q, ram_we_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0] ram_data_q, ram_data_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d, ready_q, ready_d;

  logic [9:0]       slot_s;
  logic             ucp_ok_s, beat_s, last_line_s, clear_req_s, clr_last_s;
  logic [AW-1:0]    base_s;
  logic [WIDTH-1:0] line_fmt_s;
`ifdef PUT_GLYPH_LINE_CLEAR_EN
  logic [AW-1:0]    clr_q, clr_d;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  assign clear_req_s = clear_i;
  assign clr_last_s  = (clr_q == LAST_ADDR);
`else
  assign clear_req_s = 1'b0;
  assign clr_last_s  = 1'b0;
`endif

  // A borrow out of the subtraction means ucp is below OFFSET.
  assign slot_s      = {2'b00, ucp_i} - {1'b0, UCP_LO};
  assign ucp_ok_s    = !slot_s[9] && (slot_s[8:0] < SLOTS);
  assign base_s      = AW'(slot_s[8:0]) * H_A;
  assign beat_s      = line.line_valid && ready_q;
  assign last_line_s = (cnt_q == LAST_LINE);

  // Stream bit order to RAM bit order.
  always_comb begin
    line_fmt_s = line.line_data;
    if (LSB) begin
      line_fmt_s = line.line_data;
    end else begin
      line_fmt_s = WIDTH'(bit_rev(REV_MAX'(line.line_data), WIDTH));
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear_req_s) begin
          state_d = CLEAR;
        end else if (start_i && ucp_ok_s) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (beat_s && last_line_s) begin
          state_d = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      CLEAR: begin
        if (clr_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    base_d     = base_q;
    cnt_d      = cnt_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef PUT_GLYPH_LINE_CLEAR_EN
    clr_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start_i && !clear_req_s) begin
          if (ucp_ok_s) begin
            base_d = base_s;
            cnt_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      LOAD: begin
        if (beat_s) begin
          ram_we_d   = 1'b1;
          ram_addr_d = base_q + AW'(cnt_q);
          ram_data_d = line_fmt_s;
          cnt_d      = cnt_q + CW'(1);
          done_d     = last_line_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
`ifdef PUT_GLYPH_LINE_CLEAR_EN
      CLEAR: begin
        ram_we_d   = 1'b1;
        ram_addr_d = clr_q;
        ram_data_d = '0;
        clr_d      = clr_q + AW'(1);
        done_d     = clr_last_s;
      end
`endif
      default: begin
        ram_we_d = 1'b0;
      end
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == LOAD);
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
`ifdef PUT_GLYPH_LINE_CLEAR_EN
      clr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
`ifdef PUT_GLYPH_LINE_CLEAR_EN
      clr_q      <= clr_d;
`endif
    end
  end

  assign line.line_ready = ready_q;
  assign ram_we_o        = ram_we_q;
  assign ram_addr_o      = ram_addr_q;
  assign ram_data_o      = ram_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule
